// File: rtl/console_io_pkg.sv
// console_io_pkg
// Shared types and sizing helpers for the console I/O bridge.
//   key_state_e  : keystroke player states
//   dump_state_e : memory drain states
//   count_w()    : width of an occupancy counter for a FIFO of given depth
//   bits_for()   : width needed to hold values 0..max_val (at least 1 bit)
package console_io_pkg;

  typedef enum logic {
    KEY_IDLE,
    KEY_HOLD
  } key_state_e;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_WAIT,
    DUMP_EMIT
  } dump_state_e;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/console_key_fifo.sv
// console_key_fifo
// Synchronous FIFO holding host keystrokes until the player consumes them.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : write request and data (ignored while full)
//   pop             : read request (ignored while empty)
//   head            : oldest stored word, valid whenever !empty
//   full, empty     : occupancy flags derived from count
//   count           : number of stored words, 0..KEY_DEPTH
module console_key_fifo
  import console_io_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int KEY_DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [DATA_W-1:0]              head,
  output logic                           full,
  output logic                           empty,
  output logic [count_w(KEY_DEPTH)-1:0]  count
);

  localparam int PTR_W = $clog2(KEY_DEPTH);
  localparam int CNT_W = count_w(KEY_DEPTH);

  logic [DATA_W-1:0] mem [KEY_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Full is based on current occupancy only, so a same-cycle pop never
  // reopens the input.
  assign full    = (count == CNT_W'(KEY_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/console_io_bridge.sv
// console_io_bridge
// Host-side console bridge for the core.
//  * Keystroke path: host words are queued in a FIFO; the player presents
//    each one on active_key for exactly HOLD_CYCLES cycles, back-to-back
//    while keys are waiting, and returns active_key to 0 when idle.
//  * Dump path: drains dump_len words starting at dump_base, turning the low
//    CHAR_W bits of each read word into one character on a valid/ready
//    stream; dump_done pulses once per drain.
// Ports:
//   clk, reset                              : clock, synchronous active-high reset
//   key_in_valid/key_in_data/key_in_ready   : host keystroke input
//   key_count                               : FIFO occupancy
//   active_key                              : keyboard word seen by the core
//   dump_start/dump_base/dump_len           : drain request
//   mem_addr/mem_rdata                      : memory read port
//   char_valid/char_data/char_ready         : character output stream
//   dump_busy/dump_done                     : drain status
module console_io_bridge
  import console_io_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 64,
  parameter int KEY_DEPTH    = 64,
  parameter int HOLD_CYCLES  = 10,
  parameter int READ_LATENCY = 1,
  parameter int CHAR_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           key_in_valid,
  input  logic [DATA_W-1:0]              key_in_data,
  output logic                           key_in_ready,
  output logic [count_w(KEY_DEPTH)-1:0]  key_count,
  output logic [DATA_W-1:0]              active_key,
  input  logic                           dump_start,
  input  logic [ADDR_W-1:0]              dump_base,
  input  logic [ADDR_W-1:0]              dump_len,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic                           char_valid,
  output logic [CHAR_W-1:0]              char_data,
  input  logic                           char_ready,
  output logic                           dump_busy,
  output logic                           dump_done
);

  localparam int HOLD_W = bits_for(HOLD_CYCLES - 1);
  localparam int LAT_W  = bits_for(READ_LATENCY - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(READ_LATENCY - 1);

  // ---------------- keystroke path ----------------
  key_state_e        key_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DATA_W-1:0] key_head;
  logic              key_full;
  logic              key_empty;
  logic              key_pop;

  // The player takes a new key when idle, or on the last cycle of the
  // current hold so consecutive keys abut with no gap.
  assign key_pop      = !key_empty && ((key_state == KEY_IDLE) || (hold_cnt == '0));
  assign key_in_ready = !key_full;

  console_key_fifo #(
    .DATA_W    (DATA_W),
    .KEY_DEPTH (KEY_DEPTH)
  ) u_key_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (key_in_valid),
    .push_data (key_in_data),
    .pop       (key_pop),
    .head      (key_head),
    .full      (key_full),
    .empty     (key_empty),
    .count     (key_count)
  );

  always_ff @(posedge clk) begin : key_player
    if (reset) begin
      key_state  <= KEY_IDLE;
      hold_cnt   <= '0;
      active_key <= '0;
    end else begin
      case (key_state)
        KEY_IDLE: begin
          if (!key_empty) begin
            active_key <= key_head;
            hold_cnt   <= HOLD_INIT;
            key_state  <= KEY_HOLD;
          end
        end
        KEY_HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else if (!key_empty) begin
            active_key <= key_head;
            hold_cnt   <= HOLD_INIT;
          end else begin
            active_key <= '0;
            key_state  <= KEY_IDLE;
          end
        end
        default: key_state <= KEY_IDLE;
      endcase
    end
  end

  // ---------------- memory dump path ----------------
  dump_state_e       dump_state;
  logic [ADDR_W-1:0] remaining;
  logic [LAT_W-1:0]  lat_cnt;

  // Only the low CHAR_W bits of a word form a character.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[DATA_W-1:CHAR_W];

  always_ff @(posedge clk) begin : dump_engine
    if (reset) begin
      dump_state <= DUMP_IDLE;
      mem_addr   <= '0;
      remaining  <= '0;
      lat_cnt    <= '0;
      char_valid <= 1'b0;
      char_data  <= '0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      // dump_done is a pulse: cleared every cycle unless re-asserted below.
      dump_done <= 1'b0;
      case (dump_state)
        DUMP_IDLE: begin
          if (dump_start) begin
            if (dump_len != '0) begin
              mem_addr   <= dump_base;
              remaining  <= dump_len;
              lat_cnt    <= LAT_INIT;
              dump_busy  <= 1'b1;
              dump_state <= DUMP_WAIT;
            end else begin
              dump_done <= 1'b1;
            end
          end
        end
        DUMP_WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else begin
            char_data  <= mem_rdata[CHAR_W-1:0];
            char_valid <= 1'b1;
            dump_state <= DUMP_EMIT;
          end
        end
        DUMP_EMIT: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            if (remaining > ADDR_W'(1)) begin
              mem_addr   <= mem_addr + ADDR_W'(1);
              remaining  <= remaining - ADDR_W'(1);
              lat_cnt    <= LAT_INIT;
              dump_state <= DUMP_WAIT;
            end else begin
              dump_busy  <= 1'b0;
              dump_done  <= 1'b1;
              dump_state <= DUMP_IDLE;
            end
          end
        end
        default: dump_state <= DUMP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_console_io_bridge.sv
// tb_console_io_bridge
// Self-checking bench for console_io_bridge with default parameters.
// Keystroke timing is checked against a per-cycle vector table; keystroke
// order/hold length and character stream contents are checked by monitors
// popping expectation queues filled when stimulus is driven.
module tb_console_io_bridge;
  import console_io_pkg::*;

  localparam int DATA_W       = 64;
  localparam int ADDR_W       = 64;
  localparam int KEY_DEPTH    = 64;
  localparam int HOLD_CYCLES  = 10;
  localparam int READ_LATENCY = 1;
  localparam int CHAR_W       = 8;
  localparam int CNT_W        = count_w(KEY_DEPTH);

  logic              clk;
  logic              reset;
  logic              key_in_valid;
  logic [DATA_W-1:0] key_in_data;
  logic              key_in_ready;
  logic [CNT_W-1:0]  key_count;
  logic [DATA_W-1:0] active_key;
  logic              dump_start;
  logic [ADDR_W-1:0] dump_base;
  logic [ADDR_W-1:0] dump_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              char_valid;
  logic [CHAR_W-1:0] char_data;
  logic              char_ready;
  logic              dump_busy;
  logic              dump_done;

  console_io_bridge #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .KEY_DEPTH    (KEY_DEPTH),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .READ_LATENCY (READ_LATENCY),
    .CHAR_W       (CHAR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in_valid (key_in_valid),
    .key_in_data  (key_in_data),
    .key_in_ready (key_in_ready),
    .key_count    (key_count),
    .active_key   (active_key),
    .dump_start   (dump_start),
    .dump_base    (dump_base),
    .dump_len     (dump_len),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .char_valid   (char_valid),
    .char_data    (char_data),
    .char_ready   (char_ready),
    .dump_busy    (dump_busy),
    .dump_done    (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [7:0] char_fn(input logic [63:0] a);
    case (a)
      64'h201: return 8'h48;
      64'h202: return 8'h69;
      default: return a[7:0] ^ 8'h3C;
    endcase
  endfunction

  // Upper bits are non-zero junk so a wrong character slice is visible.
  assign mem_rdata = {~mem_addr[55:0], char_fn(mem_addr)};

  // ---------------- bookkeeping ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  ch;
    logic [63:0] addr;
  } chr_exp_t;

  chr_exp_t    chr_q[$];
  logic [63:0] key_q[$];

  // ---------------- character monitor ----------------
  logic prev_done = 1'b0;

  always begin : char_mon
    chr_exp_t e;
    @(negedge clk);
    #1;
    if (!reset && char_valid) begin
      check("busy_while_valid", 64'(dump_busy), 64'(1));
      if (char_ready) begin
        if (chr_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_char: got 0x%0h, expected none", char_data);
        end else begin
          e = chr_q.pop_front();
          check("char_data", 64'(char_data), 64'(e.ch));
          check("char_addr", mem_addr, e.addr);
        end
      end
    end
    if (prev_done) check("done_one_cycle", 64'(dump_done), 64'(0));
    prev_done = dump_done;
  end

  // ---------------- keystroke monitor ----------------
  logic        key_mon_on = 1'b0;
  logic [63:0] km_prev    = '0;
  int          km_run     = 0;

  always begin : key_mon
    @(negedge clk);
    #1;
    if (key_mon_on) begin
      if (active_key !== km_prev) begin
        if (km_prev != 0) check("key_hold_len", 64'(km_run), 64'(HOLD_CYCLES));
        if (active_key != 0) begin
          if (key_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_key: got 0x%0h, expected none", active_key);
          end else begin
            check("key_order", active_key, key_q.pop_front());
          end
        end
        km_run = 1;
      end else if (active_key != 0) begin
        km_run++;
      end
      km_prev = active_key;
    end else begin
      km_prev = '0;
      km_run  = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic expect_busy);
    int c = 0;
    while (!dump_done && c < 200) begin
      check({name, "_busy"}, 64'(dump_busy), 64'(expect_busy));
      step();
      c++;
    end
    if (!dump_done) begin
      timeout_fail({name, "_done"});
    end else begin
      check({name, "_busy_end"}, 64'(dump_busy), 64'(0));
      step();
      check({name, "_done_drop"}, 64'(dump_done), 64'(0));
    end
  endtask

  task automatic run_dump(input string name, input logic [63:0] base, input logic [63:0] len);
    chr_exp_t e;
    for (longint unsigned k = 0; k < len; k++) begin
      e.addr = base + k;
      e.ch   = char_fn(e.addr);
      chr_q.push_back(e);
    end
    dump_base  = base;
    dump_len   = len;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    wait_done(name, len != 0);
    check({name, "_drained"}, 64'(chr_q.size()), 64'(0));
  endtask

  // ---------------- key timing vector table ----------------
  typedef struct {
    logic             push;
    logic [63:0]      data;
    logic [63:0]      exp_key;
    logic [CNT_W-1:0] exp_count;
  } key_vec_t;

  localparam int N_KV = 24;
  key_vec_t kv[N_KV];

  initial begin
    logic [CHAR_W-1:0] held_data;
    logic [ADDR_W-1:0] held_addr;
    logic              got;

    // Entry i: inputs for edge i+1, outputs expected after that edge.
    // 0x61 is written at edge 1, popped at edge 2 together with the write
    // of 0x62, shown for 10 cycles, then 0x62 for 10 cycles, then 0.
    for (int i = 0; i < N_KV; i++) begin
      kv[i].push      = (i < 2);
      kv[i].data      = (i == 0) ? 64'h61 : 64'h62;
      kv[i].exp_key   = (i == 0) ? 64'h0 : (i <= 10) ? 64'h61 : (i <= 20) ? 64'h62 : 64'h0;
      kv[i].exp_count = (i <= 10) ? CNT_W'(1) : CNT_W'(0);
    end

    reset        = 1'b1;
    key_in_valid = 1'b0;
    key_in_data  = '0;
    dump_start   = 1'b0;
    dump_base    = '0;
    dump_len     = '0;
    char_ready   = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_active_key", active_key, 64'(0));
    check("rst_key_count", 64'(key_count), 64'(0));
    check("rst_key_ready", 64'(key_in_ready), 64'(1));
    check("rst_mem_addr", mem_addr, 64'(0));
    check("rst_char_valid", 64'(char_valid), 64'(0));
    check("rst_char_data", 64'(char_data), 64'(0));
    check("rst_busy", 64'(dump_busy), 64'(0));
    check("rst_done", 64'(dump_done), 64'(0));
    reset = 1'b0;

    // Key timing table
    for (int i = 0; i < N_KV; i++) begin
      key_in_valid = kv[i].push;
      key_in_data  = kv[i].data;
      step();
      check($sformatf("kv%0d_active_key", i), active_key, kv[i].exp_key);
      check($sformatf("kv%0d_key_count", i), 64'(key_count), 64'(kv[i].exp_count));
    end
    key_in_valid = 1'b0;

    // FIFO fill while the player drains slowly; then full drain in order
    do_reset();
    key_q.delete();
    key_mon_on = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      key_in_valid = 1'b1;
      key_in_data  = 64'h1000 + 64'(i);
      if (key_in_ready) key_q.push_back(key_in_data);
      step();
      if (!key_in_ready) got = 1'b1;
    end
    if (!got) begin
      timeout_fail("fifo_fill");
    end else begin
      check("fifo_full_count", 64'(key_count), 64'(KEY_DEPTH));
      check("fifo_full_ready", 64'(key_in_ready), 64'(0));
      key_in_data = 64'hDEAD;
      step();
      check("fifo_refuse_count", 64'(key_count <= CNT_W'(KEY_DEPTH)), 64'(1));
    end
    key_in_valid = 1'b0;
    begin
      int c = 0;
      while ((key_q.size() != 0 || active_key != 0) && c < 1500) begin
        step();
        c++;
      end
      if (c >= 1500) timeout_fail("fifo_drain");
    end
    step();
    check("fifo_drain_count", 64'(key_count), 64'(0));
    check("fifo_drain_active", active_key, 64'(0));
    key_mon_on = 1'b0;

    // Dumps with char_ready tied high
    char_ready = 1'b1;
    run_dump("dump", 64'h201, 64'd2);
    run_dump("len0", 64'h55, 64'd0);
    run_dump("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);

    // Backpressure: outputs hold, a second dump_start is ignored
    begin
      chr_exp_t e;
      for (int k = 0; k < 2; k++) begin
        e.addr = 64'h10 + 64'(k);
        e.ch   = char_fn(e.addr);
        chr_q.push_back(e);
      end
    end
    char_ready = 1'b0;
    dump_base  = 64'h10;
    dump_len   = 64'd2;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    begin
      int c = 0;
      while (!char_valid && c < 20) begin
        step();
        c++;
      end
    end
    if (!char_valid) timeout_fail("bp_valid");
    held_data = char_data;
    held_addr = mem_addr;
    for (int i = 0; i < 5; i++) begin
      dump_start = (i == 2);
      dump_base  = 64'h999;
      dump_len   = 64'd5;
      step();
      check($sformatf("bp%0d_valid", i), 64'(char_valid), 64'(1));
      check($sformatf("bp%0d_data", i), 64'(char_data), 64'(held_data));
      check($sformatf("bp%0d_addr", i), mem_addr, held_addr);
    end
    dump_start = 1'b0;
    char_ready = 1'b1;
    wait_done("bp", 1'b1);
    check("bp_drained", 64'(chr_q.size()), 64'(0));

    // Reset while a key is held and a character is stalled
    key_in_valid = 1'b1;
    key_in_data  = 64'hABC;
    step();
    key_in_valid = 1'b0;
    step();
    char_ready = 1'b0;
    dump_base  = 64'h40;
    dump_len   = 64'd3;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    step();
    check("mid_pre_active", active_key, 64'hABC);
    check("mid_pre_valid", 64'(char_valid), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_active_key", active_key, 64'(0));
    check("mid_char_valid", 64'(char_valid), 64'(0));
    check("mid_key_count", 64'(key_count), 64'(0));
    check("mid_busy", 64'(dump_busy), 64'(0));
    check("mid_mem_addr", mem_addr, 64'(0));
    check("mid_key_ready", 64'(key_in_ready), 64'(1));
    chr_q.delete();
    char_ready = 1'b1;
    step();
    check("mid_after_active", active_key, 64'(0));
    run_dump("post_rst", 64'h300, 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
